fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param_if.sv | 48 ++++
 rtl/fifo_param.sv | 194 +++++++++++++++++++
 tb/tb_fifo_param.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// -----------------------------------------------------------------------------
// fifo_param_if -- request/response bundle for fifo_param.
//
// Groups everything except clk and reset:
//   wr_en, rd_en, d_in          requests and write data (master -> slave)
//   d_out                       registered read data    (slave -> master)
//   full, empty                 occupancy flags
//   almost_full, almost_empty   threshold flags
//   wr_ack, wr_err, rd_ack,
//   rd_err                      single-cycle handshake status
//   data_count                  stored word count, 0..2**ADDR_WIDTH
//   state                       3-bit encoded FSM state
//
// The modports are:
//   master  the user of the FIFO
//   slave   the FIFO itself
// -----------------------------------------------------------------------------
interface fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [ADDR_WIDTH:0]   data_count;
  logic [2:0]            state;

  modport master (
    output wr_en, rd_en, d_in,
    input  d_out, full, empty, almost_full, almost_empty,
    input  wr_ack, wr_err, rd_ack, rd_err, data_count, state
  );

  modport slave (
    input  wr_en, rd_en, d_in,
    output d_out, full, empty, almost_full, almost_empty,
    output wr_ack, wr_err, rd_ack, rd_err, data_count, state
  );
endinterface

// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param -- synchronous FIFO with a per-request handshake status and
// a small state machine that reports what happened on the last clock edge.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; empties the FIFO and returns to INIT
//   bus    fifo_param_if.slave (requests, data, flags, status, count, state)
//
// Parameters:
//   DATA_WIDTH  word width (default 32)
//   ADDR_WIDTH  pointer width; depth is 2**ADDR_WIDTH (default 3)
//   AF_LEVEL    almost_full threshold, count >= AF_LEVEL (default depth-1)
//   AE_LEVEL    almost_empty threshold, count <= AE_LEVEL (default 1)
//
// Build option:
//   FIFO_ALMOST_FLAGS_EN  when defined, almost_full/almost_empty are driven
//                         from the thresholds; otherwise they are tied to 0.
//
// Every request is sampled on the rising edge. The same edge updates the
// memory, pointers, count, state, d_out and the status flags, so all
// outputs reflect the request of the previous cycle.
// -----------------------------------------------------------------------------
module fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic         clk,
  input  logic         reset,
  fifo_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    RW       = 3'b011,
    WR_ERROR = 3'b101,
    RD_ERROR = 3'b110,
    NO_OP    = 3'b111
  } state_e;

  // Thresholds beyond the depth would make a flag stuck; catch that at build.
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_levels
    $error("fifo_param: AF_LEVEL/AE_LEVEL must lie in 0..2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] d_out_q;
  logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;

  state_e state_q, state_d;
  logic   do_wr, do_rd;
  logic   wr_ack_d, wr_err_d, rd_ack_d, rd_err_d;
  logic   full, empty;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // ---------------------------------------------------------------------------
  // Next state and per-request decisions. The decision depends only on the
  // request and the occupancy, never on the current state, so INIT behaves
  // exactly like every other state.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned -- that is what keeps latches out.
    state_d  = NO_OP;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;

    unique case ({bus.wr_en, bus.rd_en})
      2'b10: begin
        if (!full) begin
          state_d  = WRITE;
          do_wr    = 1'b1;
          wr_ack_d = 1'b1;
        end else begin
          state_d  = WR_ERROR;
          wr_err_d = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          state_d  = READ;
          do_rd    = 1'b1;
          rd_ack_d = 1'b1;
        end else begin
          state_d  = RD_ERROR;
          rd_err_d = 1'b1;
        end
      end
      2'b11: begin
        // When full, wr_ptr == rd_ptr: the read picks up the old word and
        // the write replaces it on the same edge, so count stays at DEPTH.
        if (!empty) begin
          state_d  = RW;
          do_wr    = 1'b1;
          do_rd    = 1'b1;
          wr_ack_d = 1'b1;
          rd_ack_d = 1'b1;
        end else begin
          state_d  = WRITE;
          do_wr    = 1'b1;
          wr_ack_d = 1'b1;
          rd_err_d = 1'b1;
        end
      end
      default: state_d = NO_OP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, read data and status. Pointers are exactly ADDR_WIDTH
  // bits, so they wrap from DEPTH-1 to 0 on their own.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      d_out_q  <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        d_out_q <= mem[rd_ptr];
      end
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the pointers and count define which words
    // are valid, so clearing it would add logic without changing behaviour.
    if (!reset && do_wr) mem[wr_ptr] <= bus.d_in;
  end

  // ---------------------------------------------------------------------------
  // Threshold flags.
  // ---------------------------------------------------------------------------
`ifdef FIFO_ALMOST_FLAGS_EN
  assign bus.almost_full  = (int'(count) >= AF_LEVEL);
  assign bus.almost_empty = (int'(count) <= AE_LEVEL);
`else
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif

  assign bus.d_out      = d_out_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.data_count = count;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_param -- directed bench for fifo_param at DEPTH=8, DATA_WIDTH=32.
// Inputs change one time unit after the rising edge; outputs are checked
// at that same point, i.e. after the edge that consumed the previous request.
// -----------------------------------------------------------------------------
module tb_fifo_param;

  localparam int DW = 32;
  localparam int AW = 3;

  localparam logic [2:0] S_INIT = 3'b000;
  localparam logic [2:0] S_WR   = 3'b001;
  localparam logic [2:0] S_RD   = 3'b010;
  localparam logic [2:0] S_RW   = 3'b011;
  localparam logic [2:0] S_WERR = 3'b101;
  localparam logic [2:0] S_RERR = 3'b110;
  localparam logic [2:0] S_NOP  = 3'b111;

  logic clk = 1'b0;
  logic reset;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks every output against the expected state, count, data and status.
  task automatic check_all(input string tag, input logic [2:0] st, input int cnt,
                           input logic [31:0] dout, input logic wa, input logic we,
                           input logic ra, input logic re);
    logic exp_af, exp_ae;
`ifdef FIFO_ALMOST_FLAGS_EN
    exp_af = (cnt >= 7);
    exp_ae = (cnt <= 1);
`else
    exp_af = 1'b0;
    exp_ae = 1'b0;
`endif
    check({tag, ".state"},        32'(bus.state),        32'(st));
    check({tag, ".count"},        32'(bus.data_count),   32'(cnt));
    check({tag, ".d_out"},        bus.d_out,             dout);
    check({tag, ".wr_ack"},       32'(bus.wr_ack),       32'(wa));
    check({tag, ".wr_err"},       32'(bus.wr_err),       32'(we));
    check({tag, ".rd_ack"},       32'(bus.rd_ack),       32'(ra));
    check({tag, ".rd_err"},       32'(bus.rd_err),       32'(re));
    check({tag, ".full"},         32'(bus.full),         32'(cnt == 8));
    check({tag, ".empty"},        32'(bus.empty),        32'(cnt == 0));
    check({tag, ".almost_full"},  32'(bus.almost_full),  32'(exp_af));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(exp_ae));
  endtask

  // Presents one request and advances past the edge that consumes it.
  task automatic cyc(input logic w, input logic r, input logic [31:0] din);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.d_in  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
    bus.d_in   = '0;

    // Reset state.
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    check_all("reset", S_INIT, 0, 32'h0, 0, 0, 0, 0);
    reset = 1'b0;

    // Fill with 1..8.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 32'(i));
      check_all($sformatf("fill%0d", i), S_WR, i, 32'h0, 1, 0, 0, 0);
    end

    // Write while full is rejected.
    cyc(1'b1, 1'b0, 32'h99);
    check_all("wr_full", S_WERR, 8, 32'h0, 0, 1, 0, 0);

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 32'h0);
      check_all($sformatf("drain%0d", i), S_RD, 8 - i, 32'(i), 0, 0, 1, 0);
    end

    // Read while empty is rejected, d_out holds.
    cyc(1'b0, 1'b1, 32'h0);
    check_all("rd_empty", S_RERR, 0, 32'h8, 0, 0, 0, 1);

    // Simultaneous request while empty: write only.
    cyc(1'b1, 1'b1, 32'h100);
    check_all("rw_empty", S_WR, 1, 32'h8, 1, 0, 0, 1);

    // Idle cycle clears status.
    cyc(1'b0, 1'b0, 32'h0);
    check_all("idle", S_NOP, 1, 32'h8, 0, 0, 0, 0);

    // Top up to full with 0x101..0x107.
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b1, 1'b0, 32'h100 + 32'(i));
      check_all($sformatf("top%0d", i), S_WR, 1 + i, 32'h8, 1, 0, 0, 0);
    end

    // Simultaneous request while full: oldest out, 0xA5 in.
    cyc(1'b1, 1'b1, 32'hA5);
    check_all("rw_full", S_RW, 8, 32'h100, 1, 0, 1, 0);

    // Drain across the pointer wrap; 0xA5 comes out last.
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 1'b1, 32'h0);
      check_all($sformatf("wrap%0d", i), S_RD, 8 - i, 32'h100 + 32'(i), 0, 0, 1, 0);
    end
    cyc(1'b0, 1'b1, 32'h0);
    check_all("wrap8", S_RD, 0, 32'hA5, 0, 0, 1, 0);

    // Load five words, then reset during a write.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0, 32'h10 + 32'(i));
      check_all($sformatf("pre%0d", i), S_WR, i, 32'hA5, 1, 0, 0, 0);
    end
    reset = 1'b1;
    cyc(1'b1, 1'b0, 32'h77);
    check_all("mid_reset", S_INIT, 0, 32'h0, 0, 0, 0, 0);
    reset = 1'b0;

    // Stored words were discarded.
    cyc(1'b0, 1'b1, 32'h0);
    check_all("post_reset_rd", S_RERR, 0, 32'h0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
